// File: rtl/modinv_32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | modinv_32 : 32-bit modular inverse (binary extended Euclid), odd m    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module modinv_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ina,
  input  logic [31:0] inm,
  output logic [31:0] result,
  output logic        ready_n,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [31:0] u, v, x1, x2, m;
  logic        seen_low;

  logic [32:0] x1_plus_m, x2_plus_m, x1_wrap, x2_wrap;
  logic [31:0] x1_half, x2_half, x1_sub, x2_sub;

  // Halving x+m needs the 33rd bit; x+m-x' always lands back in [0,m).
  always_comb begin
    x1_plus_m = {1'b0, x1} + {1'b0, m};
    x2_plus_m = {1'b0, x2} + {1'b0, m};
    x1_wrap   = x1_plus_m - {1'b0, x2};
    x2_wrap   = x2_plus_m - {1'b0, x1};
    x1_half   = x1[0] ? x1_plus_m[32:1] : (x1 >> 1);
    x2_half   = x2[0] ? x2_plus_m[32:1] : (x2 >> 1);
    x1_sub    = (x1 >= x2) ? (x1 - x2) : x1_wrap[31:0];
    x2_sub    = (x2 >= x1) ? (x2 - x1) : x2_wrap[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_n  <= 1'b1;
      err      <= 1'b0;
      result   <= 32'd0;
      u        <= 32'd0;
      v        <= 32'd0;
      x1       <= 32'd1;
      x2       <= 32'd0;
      m        <= 32'd0;
      seen_low <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            u        <= ina;
            v        <= inm;
            x1       <= 32'd1;
            x2       <= 32'd0;
            m        <= inm;
            result   <= 32'd0;
            err      <= 1'b0;
            seen_low <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (!m[0] || (m <= 32'd1) || (u == 32'd0) || (u >= m)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (u == 32'd1) begin
            result <= x1;
            state  <= DONE;
          end else if (v == 32'd1) begin
            result <= x2;
            state  <= DONE;
          end else if ((u == 32'd0) || (v == 32'd0)) begin
            err   <= 1'b1;
            state <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_sub;
          end else begin
            v  <= v - u;
            x2 <= x2_sub;
          end
        end
        DONE: begin
          // Leave only one cycle after start has been seen low.
          if (seen_low) begin
            ready_n <= 1'b1;
            state   <= IDLE;
          end else begin
            ready_n <= 1'b0;
            if (!start) seen_low <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modinv_32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_modinv_32 : directed self-checking bench for modinv_32             |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_modinv_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ina = 32'd0;
  logic [31:0] inm = 32'd0;
  logic [31:0] result;
  logic        ready_n;
  logic        err;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [63:0] prod;

  modinv_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ina     (ina),
    .inm     (inm),
    .result  (result),
    .ready_n (ready_n),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // lat = clock edges from the accept edge until ready_n is seen low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] mm,
                        input bit pulse, input bit hold, input int gap,
                        output int lat_o);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ina = a; inm = mm; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat_o = 0;
    while (ready_n && lat_o < 200) begin
      @(posedge clk);
      #1;
      lat_o++;
      if (pulse && lat_o == 5) begin
        start = 1'b1; ina = 32'd3; inm = 32'd11;
      end else if (pulse && lat_o == 6) begin
        start = 1'b0;
      end
    end
    check("ready_timeout", {31'd0, ready_n}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_n", {31'd0, ready_n}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 3*4 = 12 = 11+1
    run_op(32'd3, 32'd11, 1'b0, 1'b0, 0, lat);
    check("inv3_11_err", {31'd0, err}, 32'd0);
    check("inv3_11", result, 32'd4);
    @(posedge clk);
    #1;
    check("inv3_11_back_idle", {31'd0, ready_n}, 32'd1);

    // 17*2092 = 11*3233 + 1
    run_op(32'd17, 32'd3233, 1'b0, 1'b0, 2, lat);
    check("inv17_err", {31'd0, err}, 32'd0);
    check("inv17", result, 32'd2092);
    prod = (64'd17 * {32'd0, result}) % 64'd3233;
    check("inv17_product", prod[31:0], 32'd1);

    run_op(32'd6, 32'd9, 1'b0, 1'b0, 2, lat);
    check("gcd3_err", {31'd0, err}, 32'd1);
    check("gcd3_result", result, 32'd0);

    run_op(32'd6, 32'd40, 1'b0, 1'b0, 2, lat);
    check("even_m_err", {31'd0, err}, 32'd1);
    check("even_m_lat", lat, 32'd2);

    run_op(32'd1, 32'd7, 1'b0, 1'b0, 2, lat);
    check("a1_result", result, 32'd1);
    check("a1_lat", lat, 32'd3);

    run_op(32'd5, 32'd1, 1'b0, 1'b0, 2, lat);
    check("m1_err", {31'd0, err}, 32'd1);
    check("m1_result", result, 32'd0);
    run_op(32'd0, 32'd11, 1'b0, 1'b0, 2, lat);
    check("a0_err", {31'd0, err}, 32'd1);
    check("a0_lat", lat, 32'd2);
    run_op(32'd11, 32'd11, 1'b0, 1'b0, 2, lat);
    check("a_eq_m_err", {31'd0, err}, 32'd1);

    // -2 mod (2^32-1) inverts to -(2^31) = 0x7FFFFFFF; start pulsed mid-RUN
    run_op(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0, 2, lat);
    check("big_err", {31'd0, err}, 32'd0);
    check("big_result", result, 32'h7FFF_FFFF);
    check("big_lat_le_130", {31'd0, (lat <= 130)}, 32'd1);

    // start held through DONE: outputs stay put until start drops
    run_op(32'd3, 32'd11, 1'b0, 1'b1, 2, lat);
    repeat (4) @(posedge clk);
    #1;
    check("hold_ready_n", {31'd0, ready_n}, 32'd0);
    check("hold_result", result, 32'd4);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready_n_still", {31'd0, ready_n}, 32'd0);
    @(posedge clk);
    #1;
    check("drop_ready_n_idle", {31'd0, ready_n}, 32'd1);

    // reset mid-RUN, then restart on the first cycle after release
    @(negedge clk);
    ina = 32'hFFFF_FFFD; inm = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_n", {31'd0, ready_n}, 32'd1);
    check("abort_result", result, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    run_op(32'd3, 32'd11, 1'b0, 1'b0, 0, lat);
    check("after_abort_result", result, 32'd4);
    check("after_abort_err", {31'd0, err}, 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
